// File: rtl/logic_unit_defs.sv
// Shared definitions for the two-requester logic-unit arbiter:
// opcode encodings and FSM state encoding.
package logic_unit_defs;

  localparam logic [1:0] LU_OR   = 2'b00;
  localparam logic [1:0] LU_NOR  = 2'b01;
  localparam logic [1:0] LU_AND  = 2'b10;
  localparam logic [1:0] LU_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } lu_state_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic unit: OR / NOR / AND / NAND on WIDTH bits.
module logic_unit_core
  import logic_unit_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function; no carries between bit positions.
  always_comb begin
    y = '0;
    case (op)
      LU_OR:   y = a | b;
      LU_NOR:  y = ~(a | b);
      LU_AND:  y = a & b;
      LU_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit_core between two requesters.
// IDLE grants and captures operands, EXEC registers the result, RESP holds
// it with done until the owner acks.
// Optional: define LU_TIMEOUT_EN to abort RESP after TIMEOUT unacked cycles
// and raise the sticky timeout_err output.
module logic_unit_arbiter
  import logic_unit_defs::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             ack0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             ack1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result
`ifdef LU_TIMEOUT_EN
  ,output logic            timeout_err
`endif
);

  lu_state_t        r_state, w_state_nxt;
  logic [1:0]       r_grant;
  logic             r_last;     // last requester served; 1 so req0 wins the first tie
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_y;
  logic             w_any_req, w_pick1, w_ack_vld, w_expire;

  assign w_any_req = req0 | req1;
  // On a tie the winner is whoever was not served last.
  assign w_pick1   = req1 & (~req0 | ~r_last);
  // Only the owner's ack counts, and only while the result is presented.
  assign w_ack_vld = (r_state == RESP) & ((r_grant[0] & ack0) | (r_grant[1] & ack1));

`ifdef LU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Abort fires on the cycle the count would reach TIMEOUT; an ack wins.
  assign w_expire = (r_state == RESP) & ~w_ack_vld & (r_cnt == CW'(TIMEOUT - 1));

  // Count unacked RESP cycles; sticky error once an abort occurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == EXEC)
        r_cnt <= '0;
      else if (r_state == RESP && !w_ack_vld)
        r_cnt <= r_cnt + 1'b1;
      if (w_expire)
        r_err <= 1'b1;
    end
  end

  assign timeout_err = r_err;
`else
  assign w_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_ack_vld || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant/capture in IDLE, compute in EXEC, release on ack or abort in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any_req) begin
          r_grant <= {w_pick1, ~w_pick1};
          r_op    <= w_pick1 ? op1 : op0;
          r_a     <= w_pick1 ? a1  : a0;
          r_b     <= w_pick1 ? b1  : b0;
        end
        EXEC: r_result <= w_y;
        RESP: if (w_ack_vld || w_expire) begin
          r_grant <= 2'b00;
          r_last  <= r_grant[1];
        end
        default: r_grant <= 2'b00;
      endcase
    end
  end

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op (r_op),
    .a  (r_a),
    .b  (r_b),
    .y  (w_y)
  );

  assign grant  = r_grant;
  assign busy   = (r_state != IDLE);
  assign done0  = (r_state == RESP) & r_grant[0];
  assign done1  = (r_state == RESP) & r_grant[1];
  assign result = r_result;

endmodule
